// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM pipeline stage: blocking data-memory access with timeout and MEM-to-WB register
module mem_access_unit #(
  parameter logic [7:0]  TIMEOUT   = 8'd255,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] STValIn,
  input  logic [4:0]  destIn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        freeze,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [31:0] ALURes,
  output logic [31:0] MemRead,
  output logic [4:0]  dest,
  output logic        err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic        acc_wb_en, acc_rd;
  logic [31:0] acc_alu;
  logic [4:0]  acc_dest;

  logic mem_op, misaligned;
  logic start, retire_in, retire_acc, abort;

  assign mem_op     = MEM_R_EN_IN | MEM_W_EN_IN;
  assign misaligned = (ALUResIn[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Outputs are gated by reset so an in-flight access drops immediately.
  always_comb begin
    state_n    = state;
    freeze     = 1'b0;
    mem_req    = 1'b0;
    start      = 1'b0;
    retire_in  = 1'b0;
    retire_acc = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          freeze  = 1'b1;
          start   = 1'b1;
          state_n = ACCESS;
        end else begin
          retire_in = 1'b1;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          retire_acc = 1'b1;
          state_n    = IDLE;
        end else if (cnt == TIMEOUT - 8'd1) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!rst) begin
      freeze  = 1'b0;
      mem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= 8'd0;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      acc_wb_en <= 1'b0;
      acc_rd    <= 1'b0;
      acc_alu   <= 32'd0;
      acc_dest  <= 5'd0;
      WB_EN     <= 1'b0;
      MEM_R_EN  <= 1'b0;
      ALURes    <= 32'd0;
      MemRead   <= 32'd0;
      dest      <= 5'd0;
    end else begin
      if (start) begin
        mem_we    <= MEM_W_EN_IN;
        mem_addr  <= (ALUResIn - BASE_ADDR) >> 2;
        mem_wdata <= STValIn;
        acc_wb_en <= WB_EN_IN;
        acc_rd    <= MEM_R_EN_IN & ~MEM_W_EN_IN;
        acc_alu   <= ALUResIn;
        acc_dest  <= destIn;
        cnt       <= 8'd0;
      end
      // Bubble into WB while stalled; data fields keep their last value.
      if (freeze) begin
        WB_EN    <= 1'b0;
        MEM_R_EN <= 1'b0;
        if (state == ACCESS) cnt <= cnt + 8'd1;
      end
      if (retire_in) begin
        WB_EN    <= WB_EN_IN;
        MEM_R_EN <= MEM_R_EN_IN & ~MEM_W_EN_IN;
        ALURes   <= ALUResIn;
        MemRead  <= 32'd0;
        dest     <= destIn;
        if (mem_op) err <= 1'b1;
      end
      if (retire_acc || abort) begin
        WB_EN    <= acc_wb_en;
        MEM_R_EN <= acc_rd;
        ALURes   <= acc_alu;
        MemRead  <= (retire_acc && acc_rd) ? mem_rdata : 32'd0;
        dest     <= acc_dest;
        cnt      <= 8'd0;
        if (abort) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed scoreboard bench for mem_access_unit
module tb_mem_access_unit;

  localparam logic [7:0] TO = 8'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
  logic [31:0] ALUResIn, STValIn;
  logic [4:0]  destIn;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, freeze;
  logic        WB_EN, MEM_R_EN;
  logic [31:0] ALURes, MemRead;
  logic [4:0]  dest;
  logic        err;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] memread;
    logic [4:0]  dest;
  } wb_t;

  wb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  mem_access_unit #(.TIMEOUT(TO), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst),
    .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
    .ALUResIn(ALUResIn), .STValIn(STValIn), .destIn(destIn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .freeze(freeze),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALURes(ALURes), .MemRead(MemRead),
    .dest(dest), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One instruction through the stage. ready_at = ACCESS cycle number carrying
  // mem_ready (0 = never).
  task automatic do_op(input string tag, input bit wb, input bit r, input bit w,
                       input logic [31:0] alu, input logic [31:0] st, input logic [4:0] d,
                       input int ready_at, input logic [31:0] rdata,
                       input int exp_frz, input int exp_req,
                       input logic [31:0] exp_addr, input logic [31:0] exp_mr);
    wb_t exp, got;
    int  frz_cnt = 0, req_cnt = 0, unstable = 0;
    bit  done = 0, f, q;
    logic [31:0] a0 = '0, wd0 = '0;
    logic        we0 = 1'b0;
    @(negedge clk);
    WB_EN_IN = wb; MEM_R_EN_IN = r; MEM_W_EN_IN = w;
    ALUResIn = alu; STValIn = st; destIn = d; mem_rdata = rdata;
    exp = '{wb: wb, mr: r & ~w, alu: alu, memread: exp_mr, dest: d};
    sb.push_back(exp);
    for (int c = 0; c < 50 && !done; c++) begin
      mem_ready = (ready_at > 0 && c == ready_at);
      #1;
      f = freeze; q = mem_req;
      if (c == 0) chk({tag, " req_in_idle"}, {79'd0, q}, 80'd0);
      if (q) begin
        if (req_cnt == 0) begin a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata; end
        else if (mem_addr !== a0 || mem_we !== we0 || mem_wdata !== wd0) unstable++;
        req_cnt++;
      end
      @(posedge clk); #1;
      if (f) begin
        frz_cnt++;
        chk({tag, " bubble"}, {78'd0, WB_EN, MEM_R_EN}, 80'd0);
      end else begin
        got = '{wb: WB_EN, mr: MEM_R_EN, alu: ALURes, memread: MemRead, dest: dest};
        chk({tag, " retire"}, {9'd0, got}, {9'd0, sb.pop_front()});
        done = 1;
      end
      if (!done) @(negedge clk);
    end
    mem_ready = 1'b0;
    chk({tag, " retired"}, {79'd0, done}, 80'd1);
    chk({tag, " freeze_cycles"}, 80'(frz_cnt), 80'(exp_frz));
    chk({tag, " req_cycles"}, 80'(req_cnt), 80'(exp_req));
    if (exp_req > 0) begin
      chk({tag, " addr"}, {48'd0, a0}, {48'd0, exp_addr});
      chk({tag, " we"}, {79'd0, we0}, {79'd0, w});
      if (w) chk({tag, " wdata"}, {48'd0, wd0}, {48'd0, st});
      chk({tag, " stable"}, 80'(unstable), 80'd0);
    end
  endtask

  initial begin
    rst = 1'b0; WB_EN_IN = 0; MEM_R_EN_IN = 0; MEM_W_EN_IN = 0;
    ALUResIn = '0; STValIn = '0; destIn = '0; mem_rdata = '0; mem_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {WB_EN, MEM_R_EN, ALURes, MemRead, dest, err, mem_req, mem_we, freeze, 4'd0}, 80'd0);
    chk("reset_mem", {16'd0, mem_addr, mem_wdata}, 80'd0);
    @(negedge clk) rst = 1'b1;

    do_op("alu",       1, 0, 0, 32'h7,    32'h0,         5'd3, 0, 32'h0,         0, 0, 32'd0, 32'h0);
    do_op("load",      1, 1, 0, 32'd1032, 32'h0,         5'd4, 4, 32'hCAFE_F00D, 4, 4, 32'd2, 32'hCAFE_F00D);
    do_op("store",     0, 0, 1, 32'd1024, 32'h1234_5678, 5'd0, 1, 32'hDEAD_0000, 1, 1, 32'd0, 32'h0);
    do_op("load_b2b",  1, 1, 0, 32'd1024, 32'h0,         5'd5, 2, 32'h1234_5678, 2, 2, 32'd0, 32'h1234_5678);
    do_op("rw_both",   1, 1, 1, 32'd1028, 32'hA5A5_A5A5, 5'd6, 1, 32'hFFFF_FFFF, 1, 1, 32'd1, 32'h0);
    chk("err_clean", {79'd0, err}, 80'd0);
    do_op("timeout",   1, 1, 0, 32'd1040, 32'h0,         5'd7, 0, 32'h5555_5555, 4, 4, 32'd4, 32'h0);
    chk("err_timeout", {79'd0, err}, 80'd1);
    do_op("alu2",      1, 0, 0, 32'h99,   32'h0,         5'd8, 0, 32'h0,         0, 0, 32'd0, 32'h0);
    do_op("load2",     1, 1, 0, 32'd1036, 32'h0,         5'd9, 1, 32'h0BAD_BEEF, 1, 1, 32'd3, 32'h0BAD_BEEF);
    chk("err_sticky", {79'd0, err}, 80'd1);

    // Reset in the second ACCESS cycle discards the load.
    @(negedge clk);
    WB_EN_IN = 1; MEM_R_EN_IN = 1; MEM_W_EN_IN = 0; ALUResIn = 32'd1032; destIn = 5'd10;
    mem_rdata = 32'h1111_2222; mem_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_comb", {78'd0, mem_req, freeze}, 80'd0);
    @(posedge clk); #1;
    chk("rst_mid_outs", {WB_EN, MEM_R_EN, ALURes, MemRead, dest, err, mem_req, mem_we, 5'd0}, 80'd0);
    chk("rst_mid_addr", {48'd0, mem_addr}, 80'd0);
    @(negedge clk);
    rst = 1'b1; WB_EN_IN = 0; MEM_R_EN_IN = 0; ALUResIn = '0; destIn = '0;
    #1;
    chk("post_rst_req", {78'd0, mem_req, freeze}, 80'd0);
    @(posedge clk); #1;
    chk("post_rst_noretire", {WB_EN, MEM_R_EN, MemRead, dest, 41'd0}, 80'd0);

    do_op("ready_at_to", 1, 1, 0, 32'd1024, 32'h0, 5'd11, 4, 32'h7777_8888, 4, 4, 32'd0, 32'h7777_8888);
    chk("err_ready_wins", {79'd0, err}, 80'd0);
    do_op("misaligned",  1, 1, 0, 32'd1026, 32'h0, 5'd12, 0, 32'hEEEE_EEEE, 0, 0, 32'd0, 32'h0);
    chk("err_misaligned", {79'd0, err}, 80'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
